// File: rtl/sprite_blitter_if.sv
// ---------------------------------------------------------------------------
// sprite_blitter_if
// Groups the request, sprite ROM and frame-buffer write signals of the
// sprite blitter into one bundle.
//   master : the surroundings (game logic issuing requests, the sprite ROM
//            returning data, the frame buffer observing writes)
//   slave  : the blitter itself
// Signals:
//   start, dest_x, dest_y, spr_w, spr_h, src_base : blit request
//   rom_addr / rom_data                           : sprite ROM read port
//   fb_data_In, fb_write_address, fb_we           : frame buffer write port
//   busy, done                                    : blit status
// ---------------------------------------------------------------------------
interface sprite_blitter_if;
  logic        start;
  logic [9:0]  dest_x;
  logic [9:0]  dest_y;
  logic [6:0]  spr_w;
  logic [6:0]  spr_h;
  logic [15:0] src_base;
  logic [15:0] rom_addr;
  logic [4:0]  rom_data;
  logic [4:0]  fb_data_In;
  logic [14:0] fb_write_address;
  logic        fb_we;
  logic        busy;
  logic        done;

  modport master (
    output start, dest_x, dest_y, spr_w, spr_h, src_base, rom_data,
    input  rom_addr, fb_data_In, fb_write_address, fb_we, busy, done
  );

  modport slave (
    input  start, dest_x, dest_y, spr_w, spr_h, src_base, rom_data,
    output rom_addr, fb_data_In, fb_write_address, fb_we, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// ---------------------------------------------------------------------------
// sprite_blitter
// Copies a rectangular sprite from a synchronous sprite ROM into a 5-bit
// palette-index frame buffer at a signed destination, one pixel per clock.
// Transparent pixels are skipped and pixels falling off-screen are clipped
// (still read from ROM so the blit length depends only on the sprite size).
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous, active-high reset (aborts a blit immediately)
//   bus   : request / ROM / frame-buffer bundle (slave view)
// ---------------------------------------------------------------------------
module sprite_blitter #(
  parameter int         FB_WIDTH    = 208,
  parameter int         FB_HEIGHT   = 84,
  parameter logic [4:0] TRANSPARENT = 5'd0
) (
  input  logic            Clk,
  input  logic            Reset,
  sprite_blitter_if.slave bus
);

  localparam logic [14:0] FB_WIDTH_15  = 15'(FB_WIDTH);
  localparam logic [10:0] FB_WIDTH_11  = 11'(FB_WIDTH);
  localparam logic [10:0] FB_HEIGHT_11 = 11'(FB_HEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;

  // Latched request fields still needed after the start cycle
  logic [9:0]  dx_r;
  logic [6:0]  w_r;
  logic [6:0]  h_r;

  // Position of the pixel whose ROM read is being issued this cycle
  logic [6:0]  col_r;
  logic [6:0]  row_r;
  logic [10:0] px_r;
  logic [10:0] py_r;
  logic [14:0] fb_ptr_r;
  logic [15:0] rom_addr_r;

  // Write stage: one cycle behind the read, lined up with rom_data
  logic        wr_valid_r;
  logic [14:0] wr_addr_r;

  logic        busy_r;
  logic        done_r;

  logic        zero_size_s;
  logic        col_last_s;
  logic        row_last_s;
  logic        last_s;
  logic        pix_valid_s;
  logic        fb_we_s;
  logic [14:0] dy_ext_s;
  logic [14:0] dx_ext_s;
  logic [14:0] base_s;
  logic [14:0] row_step_s;

  // True when a signed 11-bit pixel coordinate lies inside the frame buffer
  function automatic logic in_bounds(input logic [10:0] px, input logic [10:0] py);
    return !px[10] && (px < FB_WIDTH_11) && !py[10] && (py < FB_HEIGHT_11);
  endfunction

  assign zero_size_s = (bus.spr_w == 7'd0) || (bus.spr_h == 7'd0);
  assign col_last_s  = (col_r == (w_r - 7'd1));
  assign row_last_s  = (row_r == (h_r - 7'd1));
  assign last_s      = col_last_s && row_last_s;
  assign pix_valid_s = in_bounds(px_r, py_r);

  // Start address is computed modulo 2^15; negative or off-screen bases wrap,
  // but only in-bounds pixels ever reach the port, where the value is exact.
  assign dy_ext_s   = {{5{bus.dest_y[9]}}, bus.dest_y};
  assign dx_ext_s   = {{5{bus.dest_x[9]}}, bus.dest_x};
  assign base_s     = (dy_ext_s * FB_WIDTH_15) + dx_ext_s;
  // Jump from the last column of a row to the first column of the next
  assign row_step_s = FB_WIDTH_15 + 15'd1 - {8'd0, w_r};

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (zero_size_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = READ;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      READ: begin
        if (last_s) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = READ;
        end
      end
      FLUSH:   next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register with status outputs registered from the next state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == READ) || (next_state_s == FLUSH);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Request capture, read-side pointers and the write stage
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dx_r       <= 10'd0;
      w_r        <= 7'd0;
      h_r        <= 7'd0;
      col_r      <= 7'd0;
      row_r      <= 7'd0;
      px_r       <= 11'd0;
      py_r       <= 11'd0;
      fb_ptr_r   <= 15'd0;
      rom_addr_r <= 16'd0;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= 15'd0;
    end else begin
      wr_valid_r <= (state_r == READ) && pix_valid_s;
      wr_addr_r  <= fb_ptr_r;
      if ((state_r == IDLE) && bus.start) begin
        dx_r <= bus.dest_x;
        w_r  <= bus.spr_w;
        h_r  <= bus.spr_h;
        // A zero-size request leaves the ROM address untouched
        if (!zero_size_s) begin
          col_r      <= 7'd0;
          row_r      <= 7'd0;
          px_r       <= {bus.dest_x[9], bus.dest_x};
          py_r       <= {bus.dest_y[9], bus.dest_y};
          fb_ptr_r   <= base_s;
          rom_addr_r <= bus.src_base;
        end
      end else if ((state_r == READ) && !last_s) begin
        // Sprite rows are packed with stride spr_w, so the source is linear
        rom_addr_r <= rom_addr_r + 16'd1;
        if (col_last_s) begin
          col_r    <= 7'd0;
          row_r    <= row_r + 7'd1;
          px_r     <= {dx_r[9], dx_r};
          py_r     <= py_r + 11'd1;
          fb_ptr_r <= fb_ptr_r + row_step_s;
        end else begin
          col_r    <= col_r + 7'd1;
          px_r     <= px_r + 11'd1;
          fb_ptr_r <= fb_ptr_r + 15'd1;
        end
      end
    end
  end

  // rom_data arrives in the write cycle itself, so the enable has to be
  // formed from it combinationally; wr_valid_r clears asynchronously on Reset.
  assign fb_we_s              = wr_valid_r && (bus.rom_data != TRANSPARENT);
  assign bus.fb_we            = fb_we_s;
  assign bus.fb_data_In       = fb_we_s ? bus.rom_data : 5'd0;
  assign bus.fb_write_address = wr_addr_r;
  assign bus.rom_addr         = rom_addr_r;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// ---------------------------------------------------------------------------
// tb_sprite_blitter
// Directed stimulus for sprite_blitter. Expected frame-buffer writes and done
// pulses (with the cycle they must appear in) are queued when a blit is
// issued; a monitor pops and compares whenever the DUT writes or signals done.
// ---------------------------------------------------------------------------
module tb_sprite_blitter;

  logic Clk;
  logic Reset;

  sprite_blitter_if bus ();

  sprite_blitter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [14:0] addr;
    logic [4:0]  data;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  int          dq[$];
  int          n_tests;
  int          n_fail;
  int          ec;
  int          t0;
  logic [4:0]  rom_mem [0:65535];
  logic [4:0]  rom_q;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) ec <= ec + 1;

  // Synchronous sprite ROM model: data valid the cycle after the address
  always @(posedge Clk) rom_q <= rom_mem[bus.rom_addr];
  assign bus.rom_data = rom_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic exp_wr(input int a, input int d, input int n);
    wr_t e;
    e.addr = a[14:0];
    e.data = d[4:0];
    e.cyc  = t0 + n;
    wq.push_back(e);
  endtask

  task automatic exp_done(input int n);
    dq.push_back(t0 + n);
  endtask

  // Drive one start pulse; edge 0 samples it, cycle n then has ec == t0 + n
  task automatic issue(input int dx, input int dy, input int w, input int h, input int src);
    @(posedge Clk);
    #1;
    bus.dest_x   = dx[9:0];
    bus.dest_y   = dy[9:0];
    bus.spr_w    = w[6:0];
    bus.spr_h    = h[6:0];
    bus.src_base = src[15:0];
    bus.start    = 1'b1;
    t0 = ec;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Advance to 1 time unit after the edge that opens cycle n of the blit
  task automatic at_cycle(input int n);
    while (ec < t0 + n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    check({name, "_writes_left"}, wq.size(), 0);
    check({name, "_dones_left"}, dq.size(), 0);
    wq.delete();
    dq.delete();
  endtask

  // Monitor: compare every write and every done pulse against the queues
  initial begin
    wr_t e;
    int  d;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (bus.fb_we) begin
          if (wq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d, expected none",
                     bus.fb_write_address, bus.fb_data_In, ec - t0);
          end else begin
            e = wq.pop_front();
            check("wr_addr", bus.fb_write_address, e.addr);
            check("wr_data", bus.fb_data_In, e.data);
            check("wr_cycle", ec, e.cyc);
          end
        end
        if (bus.done) begin
          if (dq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: at cycle %0d, expected none", ec - t0);
          end else begin
            d = dq.pop_front();
            check("done_cycle", ec, d);
          end
        end
      end
    end
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    ec           = 0;
    t0           = 0;
    Reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dest_x   = 10'd0;
    bus.dest_y   = 10'd0;
    bus.spr_w    = 7'd0;
    bus.spr_h    = 7'd0;
    bus.src_base = 16'd0;
    // Default ROM content: 0x10 | addr[3:0], never transparent
    for (int i = 0; i < 65536; i++) begin
      rom_mem[i] = {1'b1, i[3:0]};
    end
    rom_mem[16'h0500] = 5'd5;
    rom_mem[16'h0501] = 5'd0;
    rom_mem[16'h0502] = 5'd7;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_fb_we", bus.fb_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_fb_addr", bus.fb_write_address, 0);
    check("rst_fb_data", bus.fb_data_In, 0);
    Reset = 1'b0;

    // Basic 4x2 blit at (10,5): rows at 5*208+10 = 1050 and 6*208+10 = 1258
    issue(10, 5, 4, 2, 16'h0100);
    for (int i = 0; i < 8; i++) begin
      exp_wr((i < 4) ? (1050 + i) : (1258 + i - 4), 16 + i, 2 + i);
    end
    exp_done(10);
    at_cycle(1);
    check("basic_busy_c1", bus.busy, 1);
    check("basic_rom_addr_c1", bus.rom_addr, 16'h0100);
    at_cycle(9);
    check("basic_busy_c9", bus.busy, 1);
    at_cycle(10);
    check("basic_busy_c10", bus.busy, 0);
    at_cycle(14);
    drain("basic");

    // Zero width: no reads, no writes, done in cycle 1, busy never high
    issue(3, 3, 0, 5, 16'h0700);
    exp_done(1);
    at_cycle(1);
    check("zero_busy_c1", bus.busy, 0);
    check("zero_rom_addr_held", bus.rom_addr, 16'h0107);
    at_cycle(4);
    check("zero_rom_addr_after", bus.rom_addr, 16'h0107);
    drain("zero");

    // Transparency: ROM {5,0,7} at (0,0), middle pixel skipped
    issue(0, 0, 3, 1, 16'h0500);
    exp_wr(0, 5, 2);
    exp_wr(2, 7, 4);
    exp_done(5);
    at_cycle(3);
    check("transp_we_c3", bus.fb_we, 0);
    at_cycle(8);
    drain("transp");

    // Clipping: 4x4 at (-2,82), only px 0..1 / py 82..83 survive
    issue(-2, 82, 4, 4, 16'h0400);
    exp_wr(17056, 16'h12, 4);
    exp_wr(17057, 16'h13, 5);
    exp_wr(17264, 16'h16, 8);
    exp_wr(17265, 16'h17, 9);
    exp_done(18);
    at_cycle(1);
    check("clip_rom_addr_c1", bus.rom_addr, 16'h0400);
    at_cycle(16);
    check("clip_rom_addr_c16", bus.rom_addr, 16'h040F);
    at_cycle(17);
    check("clip_rom_addr_flush", bus.rom_addr, 16'h040F);
    check("clip_busy_flush", bus.busy, 1);
    at_cycle(21);
    drain("clip");

    // Start while busy (READ) and while in DONE: both ignored
    issue(20, 10, 2, 2, 16'h0600);
    exp_wr(2100, 16'h10, 2);
    exp_wr(2101, 16'h11, 3);
    exp_wr(2308, 16'h12, 4);
    exp_wr(2309, 16'h13, 5);
    exp_done(6);
    at_cycle(2);
    bus.dest_x   = 10'd100;
    bus.spr_w    = 7'd3;
    bus.src_base = 16'h0800;
    bus.start    = 1'b1;
    at_cycle(3);
    bus.start = 1'b0;
    at_cycle(6);
    bus.start = 1'b1;
    at_cycle(7);
    bus.start = 1'b0;
    check("restart_busy_c7", bus.busy, 0);
    at_cycle(14);
    check("restart_rom_addr", bus.rom_addr, 16'h0603);
    drain("restart");

    // Reset in cycle 4 of an 8x8 blit: only cycles 2 and 3 write
    issue(0, 0, 8, 8, 16'h0200);
    exp_wr(0, 16'h10, 2);
    exp_wr(1, 16'h11, 3);
    at_cycle(4);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_fb_we", bus.fb_we, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    at_cycle(7);
    Reset = 1'b0;
    at_cycle(10);
    drain("abort");

    // 1x1 at the bottom-right corner after the abort
    issue(207, 83, 1, 1, 16'h0300);
    exp_wr(17471, 16'h10, 2);
    exp_done(3);
    at_cycle(2);
    check("corner_busy_c2", bus.busy, 1);
    at_cycle(8);
    drain("corner");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
